// File: rtl/lmsm_reg_sequencer.sv
// LM/SM register-list sequencer: walks the imm8 mask lowest-bit-first, one register per step_ready.
// reg_idx/mem_addr are combinational from registered state; done pulses one cycle after the last step.
module lmsm_reg_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        imm8,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              step_ready,
  output logic              xfer_valid,
  output logic [2:0]        reg_idx,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        xfer_count,
  output logic [7:0]        pending_mask
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        pend, pend_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [2:0]        low_idx;
  logic [7:0]        clr_mask;

  // Descending scan so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) low_idx = 3'(i);
    end
  end

  assign clr_mask = 8'd1 << low_idx;

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    addr_nxt  = addr;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          pend_nxt  = imm8;
          addr_nxt  = base_addr;
          cnt_nxt   = '0;
          state_nxt = (imm8 != 8'd0) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        if (step_ready) begin
          pend_nxt = pend & ~clr_mask;
          addr_nxt = addr + ADDR_W'(ADDR_STEP);
          cnt_nxt  = cnt + 4'd1;
          if ((pend & ~clr_mask) == 8'd0) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pend  <= '0;
      addr  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
      addr  <= addr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Index and address are forced to zero whenever no transfer is being requested.
  assign xfer_valid   = (state == S_XFER);
  assign reg_idx      = xfer_valid ? low_idx : 3'd0;
  assign mem_addr     = xfer_valid ? addr : '0;
  assign busy         = (state == S_XFER) || (state == S_DONE);
  assign done         = (state == S_DONE);
  assign xfer_count   = cnt;
  assign pending_mask = pend;

endmodule

// File: tb/tb_lmsm_reg_sequencer.sv
// Bench for lmsm_reg_sequencer: queue-based transfer model checked every cycle, plus directed literal checks.
module tb_lmsm_reg_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  imm8 = 8'd0;
  logic [15:0] base_addr = 16'd0;
  logic        step_ready = 1'b0;
  logic        xfer_valid;
  logic [2:0]  reg_idx;
  logic [15:0] mem_addr;
  logic        busy;
  logic        done;
  logic [3:0]  xfer_count;
  logic [7:0]  pending_mask;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  lmsm_reg_sequencer #(.ADDR_W(16), .ADDR_STEP(1)) dut (
    .clk(clk), .reset(reset), .start(start), .imm8(imm8), .base_addr(base_addr),
    .step_ready(step_ready), .xfer_valid(xfer_valid), .reg_idx(reg_idx),
    .mem_addr(mem_addr), .busy(busy), .done(done), .xfer_count(xfer_count),
    .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the remaining registers as an ascending queue of indices.
  int          q[$];
  bit          m_active = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_addr = 16'd0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_done = 1'b0;
      m_addr = 16'd0;
      m_cnt = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (step_ready) begin
        void'(q.pop_front());
        m_addr = m_addr + 16'd1;
        m_cnt++;
        if (q.size() == 0) begin
          m_active = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start) begin
      q.delete();
      for (int i = 0; i < 8; i++) if (imm8[i]) q.push_back(i);
      m_addr = base_addr;
      m_cnt = 0;
      if (q.size() == 0) m_done = 1'b1;
      else m_active = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        logic [7:0] m_mask;
        m_mask = 8'd0;
        foreach (q[k]) m_mask[q[k]] = 1'b1;
        chk("xfer_valid", int'(xfer_valid), int'(m_active));
        chk("busy", int'(busy), int'(m_active || m_done));
        chk("done", int'(done), int'(m_done));
        chk("xfer_count", int'(xfer_count), m_cnt);
        chk("pending_mask", int'(pending_mask), int'(m_mask));
        chk("reg_idx", int'(reg_idx), m_active ? q[0] : 0);
        chk("mem_addr", int'(mem_addr), m_active ? int'(m_addr) : 0);
      end
    end
  end

  // Observed transfers and timing, for the literal directed checks.
  int log_idx[$];
  int log_adr[$];
  int ncyc = 0;
  int start_cyc = -1;
  int done_cyc = -1;

  always @(negedge clk) begin
    ncyc++;
    if (!reset) begin
      if (xfer_valid && step_ready) begin
        log_idx.push_back(int'(reg_idx));
        log_adr.push_back(int'(mem_addr));
      end
      if (start && start_cyc == -1) start_cyc = ncyc;
      if (done && done_cyc == -1) done_cyc = ncyc;
    end
  end

  task automatic clear_log();
    log_idx.delete();
    log_adr.delete();
    start_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_xfer(input string name, input int k, input int idx, input int adr);
    if (k < log_idx.size()) begin
      chk({name, "_idx"}, log_idx[k], idx);
      chk({name, "_addr"}, log_adr[k], adr);
    end else begin
      chk({name, "_missing"}, log_idx.size(), k + 1);
    end
  endtask

  // mode 0: ready tied high, 1: toggling 1,0,1,0..., 2: random
  task automatic run_seq(input logic [7:0] m, input logic [15:0] b, input int mode, input bit noise);
    bit tog;
    tog = 1'b1;
    clear_log();
    start = 1'b1;
    imm8 = m;
    base_addr = b;
    step_ready = 1'b1;
    step();
    for (int k = 0; k < 200; k++) begin
      if (done_cyc != -1) break;
      if (noise && k == 1) begin
        start = 1'b1;
        imm8 = 8'h01;
        base_addr = 16'h0500;
      end else begin
        start = (mode == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
        imm8 = 8'($urandom);
        base_addr = 16'($urandom);
      end
      case (mode)
        0: step_ready = 1'b1;
        1: begin step_ready = tog; tog = ~tog; end
        default: step_ready = 1'($urandom);
      endcase
      step();
    end
    start = 1'b0;
    step_ready = 1'b0;
    if (done_cyc == -1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    step();
    step();
    chk_en = 1'b1;
    reset = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending_mask), 0);
    chk("rst_count", int'(xfer_count), 0);
    step();

    run_seq(8'b1010_0100, 16'h0040, 0, 1'b0);
    chk_xfer("t1_x0", 0, 2, 16'h0040);
    chk_xfer("t1_x1", 1, 5, 16'h0041);
    chk_xfer("t1_x2", 2, 7, 16'h0042);
    chk("t1_nxfer", log_idx.size(), 3);
    chk("t1_count", int'(xfer_count), 3);
    chk("t1_latency", done_cyc - start_cyc, 4);

    run_seq(8'h00, 16'h1234, 0, 1'b0);
    chk("t2_nxfer", log_idx.size(), 0);
    chk("t2_count", int'(xfer_count), 0);
    chk("t2_latency", done_cyc - start_cyc, 1);

    run_seq(8'hFF, 16'h1000, 1, 1'b0);
    for (int i = 0; i < 8; i++) chk_xfer("t3", i, i, 16'h1000 + i);
    chk("t3_count", int'(xfer_count), 8);

    run_seq(8'b1000_0001, 16'hFFFF, 0, 1'b0);
    chk_xfer("t4_x0", 0, 0, 16'hFFFF);
    chk_xfer("t4_x1", 1, 7, 16'h0000);

    run_seq(8'b1010_0100, 16'h0040, 0, 1'b1);
    chk_xfer("t5_x0", 0, 2, 16'h0040);
    chk_xfer("t5_x1", 1, 5, 16'h0041);
    chk_xfer("t5_x2", 2, 7, 16'h0042);
    chk("t5_nxfer", log_idx.size(), 3);

    clear_log();
    start = 1'b1;
    imm8 = 8'h07;
    base_addr = 16'h0000;
    step_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t6_pending_before", int'(pending_mask), 8'h06);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step_ready = 1'b0;
    chk("t6_busy", int'(busy), 0);
    chk("t6_valid", int'(xfer_valid), 0);
    chk("t6_pending", int'(pending_mask), 0);
    chk("t6_count", int'(xfer_count), 0);
    step();
    chk("t6_no_done", done_cyc, -1);
    run_seq(8'h30, 16'h0020, 0, 1'b0);
    chk_xfer("t6_x0", 0, 4, 16'h0020);
    chk_xfer("t6_x1", 1, 5, 16'h0021);

    for (int r = 0; r < 40; r++) begin
      run_seq(8'($urandom), 16'($urandom), 2, 1'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lmsm_reg_sequencer.md
Name: lmsm_reg_sequencer

Overview:
- Multicycle LM/SM (load/store multiple) register-list sequencer. Consumes the imm8 register mask from the instruction.
- Each transfer step does three things:
  - finds the lowest set bit,
  - presents its register index and memory address to the datapath,
  - decodes that index back to a one-hot clear mask, so the bit is retired on handshake.
- Sits between the controller FSM and the register-file/memory address muxes. Runs one register transfer per accepted step.

Parameters:
- ADDR_W, 16, width of memory address path.
- ADDR_STEP, 1, address increment per transferred register (word addressing).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin sequence; sampled only in IDLE.
- imm8  input  8  register mask; bit i set = transfer R[i].
- base_addr  input  ADDR_W  starting memory address.
- step_ready  input  1  datapath has completed the current transfer.
- xfer_valid  output  1  reg_idx/mem_addr valid, transfer requested.
- reg_idx  output  3  register index for current transfer.
- mem_addr  output  ADDR_W  memory address for current transfer.
- busy  output  1  high in XFER and DONE states.
- done  output  1  one-cycle pulse at end of sequence.
- xfer_count  output  4  transfers completed in current/last sequence (0..8).
- pending_mask  output  8  bits not yet transferred.

Behaviour:
- Reset (synchronous, clk edge with reset=1) forces all outputs to 0 and the state to IDLE, regardless of current state. Reset mid-sequence abandons remaining transfers, and no done pulse is issued.
  - Reset values: xfer_valid=0, reg_idx=0, mem_addr=0, busy=0, done=0, xfer_count=0, pending_mask=0.
- States:
  - IDLE: busy=0, xfer_valid=0. On start=1:
    - pending_mask<=imm8, addr<=base_addr, xfer_count<=0.
    - If imm8!=0, go to XFER. If imm8==0, go to DONE, with no transfers.
  - XFER: busy=1, xfer_valid=1.
    - reg_idx = index of lowest set bit of pending_mask. This is combinational from registered state, so it is valid the same cycle the state is entered.
    - mem_addr = registered addr.
    - On step_ready=1:
      - pending_mask <= pending_mask & ~onehot(reg_idx).
      - addr <= addr + ADDR_STEP, wrapping modulo 2^ADDR_W.
      - xfer_count <= xfer_count + 1.
      - If the new mask is 0, go to DONE; else stay in XFER with the next index.
    - step_ready=0 holds all state; reg_idx and mem_addr stay stable.
  - DONE: busy=1, done=1 for exactly one cycle, xfer_valid=0, then unconditionally go to IDLE. xfer_count and pending_mask (=0) hold until the next start.
- Latency:
  - start to first xfer_valid: 1 cycle.
  - Each step_ready retires exactly one register.
  - Last step_ready to done: 1 cycle.
  - Total cycles from start to done, with step_ready tied high: popcount(imm8)+1. For imm8==0: 1 cycle, start to done.
- Ordering: registers are always transferred in ascending index order. Addresses are consecutive from base_addr.
- start while busy (XFER/DONE) is ignored; imm8 and base_addr are not resampled.
- start in the same cycle as the DONE pulse is ignored. start is accepted on the next cycle in IDLE.
- step_ready outside XFER is ignored.
- imm8=8'hFF transfers all 8 registers; xfer_count reaches 8 (4-bit, no overflow).
- Address wrap: base_addr=16'hFFFF with 2 registers gives addresses FFFF, then 0000.
- Both the decode (index to one-hot) and the lowest-set-bit search are purely internal; no extra latency.

Test Plan:
- imm8=8'b1010_0100, base_addr=16'h0040, step_ready=1 → transfers 3 registers:
  - (reg_idx, mem_addr) = (2, 0040), (5, 0041), (7, 0042);
  - done pulses 1 cycle after the third step;
  - xfer_count=3.
- imm8=8'h00, start → no xfer_valid; done pulses 1 cycle after start; xfer_count=0.
- imm8=8'hFF, base=16'h1000, step_ready toggling 1,0,1,0 → indices 0..7 at addresses 1000..1007; each held stable while step_ready=0; xfer_count=8.
- imm8=8'b1000_0001, base=16'hFFFF → (0, FFFF) then (7, 0000); done.
- Second start mid-sequence with imm8=8'h01 → ignored; original mask completes unchanged.
- reset=1 during XFER with 2 bits pending → next cycle all outputs 0 and IDLE, no done. A new start then runs normally.
